// File: rtl/int_to_float_norm.sv
// int_to_float_norm: 16-bit two's-complement integer to {sign, exp[3:0], frac[7:0]} float,
// normalized by one left shift per clock behind valid/ready handshakes.
module int_to_float_norm (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_int,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [12:0] o_float,
  output logic        o_ovf,
  output logic        o_valid,
  input  logic        i_ready
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, state_n;
  logic [14:0] sr, sr_n, mag;
  logic [3:0] ex, ex_n;
  logic sign, sign_n, ovf_n, valid_n;
  logic [12:0] flt_n;
  // 0x8000 has no 15-bit magnitude; it is caught before mag is used
  assign mag = i_int[15] ? 15'(-i_int) : i_int[14:0];
  always_comb begin
    state_n = state;
    sr_n = sr;
    ex_n = ex;
    sign_n = sign;
    flt_n = o_float;
    ovf_n = o_ovf;
    valid_n = o_valid;
    case (state)
      IDLE: if (i_valid) begin
        sign_n = i_int[15];
        if (i_int == 16'h8000) begin
          flt_n = 13'h1FFF;
          ovf_n = 1'b1;
          valid_n = 1'b1;
          state_n = DONE;
        end else if (mag == '0) begin
          flt_n = '0;
          ovf_n = 1'b0;
          valid_n = 1'b1;
          state_n = DONE;
        end else begin
          sr_n = mag;
          ex_n = 4'hF;
          state_n = NORM;
        end
      end
      NORM: if (sr[14]) begin
        flt_n = {sign, ex, sr[14:7]};
        ovf_n = 1'b0;
        valid_n = 1'b1;
        state_n = DONE;
      end else begin
        sr_n = sr << 1;
        ex_n = ex - 4'd1;
      end
      DONE: if (i_ready) begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      sr <= '0;
      ex <= '0;
      sign <= 1'b0;
      o_float <= '0;
      o_ovf <= 1'b0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      state <= state_n;
      sr <= sr_n;
      ex <= ex_n;
      sign <= sign_n;
      o_float <= flt_n;
      o_ovf <= ovf_n;
      o_valid <= valid_n;
      o_ready <= (state_n == IDLE);
    end
  end
endmodule

// File: tb/tb_int_to_float_norm.sv
// tb_int_to_float_norm: directed vector table, handshake/reset sequences and
// randomized operands checked against an arithmetic model of the float format.
module tb_int_to_float_norm;
  logic i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0, i_ready = 1'b0;
  logic [15:0] i_int = '0;
  logic o_ready, o_ovf, o_valid;
  logic [12:0] o_float;
  int checks = 0, errors = 0;

  int_to_float_norm dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_int(i_int), .i_valid(i_valid), .o_ready(o_ready),
    .o_float(o_float), .o_ovf(o_ovf), .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] in;
    logic [12:0] flt;
    logic ovf;
    int lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // value = 0.frac * 2^exp with frac[7] the leading one; low bits truncated
  function automatic void model(input logic [15:0] v, output logic [12:0] flt,
                                output logic ovf, output int lat);
    int x, m, p, f;
    x = int'($signed(v));
    ovf = 1'b0;
    if (x == -32768) begin
      flt = 13'h1FFF; ovf = 1'b1; lat = 1;
    end else if (x == 0) begin
      flt = '0; lat = 1;
    end else begin
      m = (x < 0) ? -x : x;
      p = 0;
      while ((m >> (p + 1)) != 0) p++;
      f = (p >= 7) ? (m >> (p - 7)) : (m << (7 - p));
      flt = {(x < 0), 4'(p + 1), 8'(f)};
      lat = 14 - p + 2;
    end
  endfunction

  task automatic convert(input logic [15:0] v, input logic [12:0] eflt, input logic eovf,
                         input int elat, input int stall);
    int lat, w;
    logic busy_bad;
    logic [12:0] held;
    w = 0;
    while (!o_ready && w < 40) begin
      @(posedge i_clk); #1; w++;
    end
    check("ready_before_accept", o_ready, 1);
    i_int = v; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_int = 16'($urandom);
    lat = 1;
    busy_bad = 1'b0;
    while (!o_valid && lat < 40) begin
      if (o_ready) busy_bad = 1'b1;
      @(posedge i_clk); #1; lat++;
    end
    check("latency", lat, elat);
    check("float", o_float, eflt);
    check("ovf", o_ovf, eovf);
    check("ready_low_busy", {busy_bad, o_ready}, 0);
    held = o_float;
    for (int i = 0; i < stall; i++) begin
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      check("stall_hold", {o_valid, o_ready, o_float}, {1'b1, 1'b0, held});
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    check("release", {o_valid, o_ready}, 2'b01);
  endtask

  vec_t vecs[8];

  initial begin
    logic [12:0] mf;
    logic mo;
    int ml;
    logic [15:0] r;
    vecs[0] = '{16'h4000, 13'h0F80, 1'b0, 2};
    vecs[1] = '{16'h0001, 13'h0180, 1'b0, 16};
    vecs[2] = '{16'hFFFB, 13'h13A0, 1'b0, 14};
    vecs[3] = '{16'h0000, 13'h0000, 1'b0, 1};
    vecs[4] = '{16'h8000, 13'h1FFF, 1'b1, 1};
    vecs[5] = '{16'h7FFF, 13'h0FFF, 1'b0, 2};
    vecs[6] = '{16'h01FF, 13'h09FF, 1'b0, 8};
    vecs[7] = '{16'h8001, 13'h1FFF, 1'b0, 2};

    repeat (2) @(posedge i_clk);
    #1;
    check("reset_outputs", {o_float, o_ovf, o_valid}, 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("ready_after_reset", o_ready, 1);

    foreach (vecs[i]) convert(vecs[i].in, vecs[i].flt, vecs[i].ovf, vecs[i].lat, 0);

    convert(16'h00C3, 13'h08C3, 1'b0, 9, 5);
    convert(16'hFF00, 13'h1980, 1'b0, 8, 0);

    // reset in the middle of a long normalization
    i_int = 16'h0001; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1 check("async_reset_outputs", {o_float, o_ovf, o_valid}, 0);
    @(posedge i_clk); #2 i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("ready_after_midnorm_reset", {o_ready, o_valid}, 2'b10);
    convert(16'h4000, 13'h0F80, 1'b0, 2, 0);

    for (int n = 0; n < 200; n++) begin
      r = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) r = -r;
      if (n == 50) r = 16'h8000;
      model(r, mf, mo, ml);
      convert(r, mf, mo, ml, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/int_to_float_norm.md
Name: int_to_float_norm

Overview:
- Sequential converter: 16-bit two's-complement integer in, 13-bit float out in the comparator format {sign[12], exp[11:8], frac[7:0]}.
- Value encoding is 0.frac × 2^exp: unsigned exponent, explicit leading 1 in frac[7] when normalized, zero encoded as all-zero.
- Sits directly upstream of the float greater-than comparator. It turns ADC/counter integers into normalized operands.
- Normalization is iterative, one left shift per clock, wrapped in valid/ready handshakes on both sides.

Parameters:
- None. The format is fixed at 1/4/8 bits to match the comparator, and the input is fixed at 16 bits.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_int  in  16  two's-complement integer operand
- i_valid  in  1  operand valid
- o_ready  out  1  converter can accept an operand (high only in IDLE)
- o_float  out  13  result {sign, exp[3:0], frac[7:0]}
- o_ovf  out  1  saturation flag, qualified by o_valid
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result

Behaviour:
- Reset (async, active-high, at any time, including mid-NORM):
  - state=IDLE; o_float=0, o_ovf=0, o_valid=0; internal shift register and exponent cleared.
  - o_ready=1 in the first cycle after reset deasserts.
- States:
  - IDLE: o_ready=1. On i_valid at a clock edge, capture the operand:
    - sign s = i_int[15]; magnitude M = |i_int| (15 bits).
    - If i_int = 0x8000: result {1,1111,0xFF}, o_ovf=1, go to DONE (saturation).
    - Else if M = 0: result 0x0000 (sign forced 0), go to DONE (zero fast path).
    - Else: S[14:0]=M, E=15, go to NORM.
  - NORM, evaluated once per cycle:
    - If S[14]=1: latch o_float={s, E, S[14:7]}, o_ovf=0, go to DONE.
    - Else: S<=S<<1 (zero fill), E<=E-1.
    - E never reaches 0 here because M≠0 guarantees a 1 within 14 shifts.
  - DONE: o_valid=1; o_float and o_ovf held stable. On i_ready: go to IDLE, o_valid<=0.
- Latency is counted from the accept edge (cycle 0) to the first cycle with o_valid=1:
  - zero or saturation: 1
  - otherwise: k+2, where k = 14 − (index of the MSB of M); range 2..16.
- Throughput: one conversion per (latency + 1 + stall) cycles. There is no input acceptance while busy; o_ready=0 in NORM and DONE.
- Bits of M below the 8-bit window are truncated (round toward zero); there is no sticky or round bit.
- i_valid in NORM/DONE is ignored; the upstream source must hold it until o_ready.
- i_ready in IDLE/NORM is ignored. o_valid never drops without an i_ready handshake except on reset.
- o_float holds its last value in IDLE; consumers use o_valid only.
- Every output of this block is a flop, with no combinational path from input to output. This is so the comparator's combinational path stays short.

Test Plan:
- Reset then i_int=0x4000 → o_float=0x0F80, o_ovf=0, o_valid two cycles after accept; o_ready low in between.
- i_int=0x0001 → o_float=0x0180 after 16 cycles. i_int=0xFFFB (−5) → o_float=0x13A0 after 14 cycles.
- i_int=0x0000 → 0x0000 at latency 1. i_int=0x8000 → o_float=0x1FFF, o_ovf=1 at latency 1.
- i_int=0x7FFF → o_float=0x0FFF (latency 2). i_int=0x01FF → o_float=0x09FF with truncation (M=511, frac=0xFF, exp=9).
- Backpressure: i_ready low for 5 cycles in DONE → o_valid and o_float stable and o_ready=0 throughout. i_ready high → IDLE next cycle. A back-to-back second operand is accepted then.
- Assert i_rst during NORM for i_int=0x0001 → all outputs 0 immediately, o_ready=1 after release, and the next conversion of 0x4000 is correct.
